// File: rtl/l3_ar_qos_arbiter_if.sv
// AR-channel bundle between the 16 masters and the L3 request pipeline.
// The arbiter takes the slave view and the masters/pipeline take the master view.
interface l3_ar_qos_arbiter_if #(
    parameter int NUM_PORTS = 16,
    parameter int ADDR_W    = 32,
    parameter int QOS_W     = 4
) ();
    localparam int IDX_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]             s_arvalid;
    logic [NUM_PORTS-1:0]             s_arready;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] s_araddr;
    logic [NUM_PORTS-1:0][7:0]        s_arlen;
    logic [NUM_PORTS-1:0][2:0]        s_arsize;
    logic [NUM_PORTS-1:0][1:0]        s_arburst;
    logic [NUM_PORTS-1:0][QOS_W-1:0]  s_arqos;

    logic                             m_arvalid;
    logic                             m_arready;
    logic [ADDR_W-1:0]                m_araddr;
    logic [7:0]                       m_arlen;
    logic [2:0]                       m_arsize;
    logic [1:0]                       m_arburst;
    logic [QOS_W-1:0]                 m_arqos;
    logic [IDX_W-1:0]                 m_arsrc;
    logic                             aged_grant;

    modport slave (
        input  s_arvalid, s_araddr, s_arlen, s_arsize, s_arburst, s_arqos, m_arready,
        output s_arready, m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arqos,
               m_arsrc, aged_grant
    );

    modport master (
        output s_arvalid, s_araddr, s_arlen, s_arsize, s_arburst, s_arqos, m_arready,
        input  s_arready, m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_arqos,
               m_arsrc, aged_grant
    );
endinterface

// File: rtl/l3_ar_qos_arbiter.sv
// 16:1 AR arbiter for the L3 slice: QoS priority, round-robin tie-break and an
// age-based starvation escape, feeding a one-entry registered output stage.
module l3_ar_qos_arbiter #(
    parameter int NUM_PORTS = 16,
    parameter int ADDR_W    = 32,
    parameter int QOS_W     = 4,
    parameter int AGE_MAX   = 15
) (
    input  logic                clk,
    input  logic                rst,
    l3_ar_qos_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_PORTS);
    localparam int AGE_W = 4;
    localparam logic [AGE_W-1:0] AGE_SAT = AGE_W'(AGE_MAX);

    logic [NUM_PORTS-1:0][AGE_W-1:0] age_r;
    logic [IDX_W-1:0]                rr_ptr_r;

    logic                 slot_free_s;
    logic                 grant_s;
    logic                 any_aged_s;
    logic [NUM_PORTS-1:0] aged_vec_s;
    logic [NUM_PORTS-1:0] cand_s;
    logic [QOS_W-1:0]     max_qos_s;
    logic [IDX_W-1:0]     win_s;
    logic                 found_s;

    // Aged-port detection and highest QoS among valid requesters
    always_comb begin
        max_qos_s = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            aged_vec_s[i] = bus.s_arvalid[i] && (age_r[i] == AGE_SAT);
            if (bus.s_arvalid[i] && (bus.s_arqos[i] > max_qos_s)) begin
                max_qos_s = bus.s_arqos[i];
            end else begin
                max_qos_s = max_qos_s;
            end
        end
        any_aged_s = |aged_vec_s;
    end

    // Candidate set: aged ports override QoS entirely
    always_comb begin
        cand_s = '0;
        if (any_aged_s) begin
            cand_s = aged_vec_s;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cand_s[i] = bus.s_arvalid[i] && (bus.s_arqos[i] == max_qos_s);
            end
        end
    end

    // Round-robin search starting just after the last winner, wrapping 15 -> 0
    always_comb begin
        logic [IDX_W-1:0] idx;
        idx     = '0;
        win_s   = '0;
        found_s = 1'b0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = rr_ptr_r + IDX_W'(k);
            if (!found_s && cand_s[idx]) begin
                win_s   = idx;
                found_s = 1'b1;
            end else begin
                win_s   = win_s;
            end
        end
    end

    // Grant decision and one-hot accept toward the masters
    always_comb begin
        slot_free_s   = !bus.m_arvalid || bus.m_arready;
        grant_s       = slot_free_s && found_s && !rst;
        bus.s_arready = '0;
        if (grant_s) begin
            bus.s_arready = {{(NUM_PORTS-1){1'b0}}, 1'b1} << win_s;
        end else begin
            bus.s_arready = '0;
        end
    end

    // Output stage: load on grant (replacing a draining entry), else drain or hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.m_arvalid  <= 1'b0;
            bus.m_araddr   <= '0;
            bus.m_arlen    <= 8'd0;
            bus.m_arsize   <= 3'd0;
            bus.m_arburst  <= 2'd0;
            bus.m_arqos    <= '0;
            bus.m_arsrc    <= '0;
            bus.aged_grant <= 1'b0;
            rr_ptr_r       <= IDX_W'(NUM_PORTS - 1);
        end else if (grant_s) begin
            bus.m_arvalid  <= 1'b1;
            bus.m_araddr   <= bus.s_araddr[win_s];
            bus.m_arlen    <= bus.s_arlen[win_s];
            bus.m_arsize   <= bus.s_arsize[win_s];
            bus.m_arburst  <= bus.s_arburst[win_s];
            bus.m_arqos    <= bus.s_arqos[win_s];
            bus.m_arsrc    <= win_s;
            bus.aged_grant <= any_aged_s;
            rr_ptr_r       <= win_s;
        end else begin
            if (bus.m_arready) begin
                bus.m_arvalid <= 1'b0;
            end else begin
                bus.m_arvalid <= bus.m_arvalid;
            end
            bus.aged_grant <= 1'b0;
        end
    end

    // Per-port wait counters; stalled cycles behind a full slot still count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            age_r <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (!bus.s_arvalid[i] || (grant_s && (win_s == IDX_W'(i)))) begin
                    age_r[i] <= '0;
                end else if (age_r[i] != AGE_SAT) begin
                    age_r[i] <= age_r[i] + AGE_W'(1);
                end else begin
                    age_r[i] <= age_r[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_l3_ar_qos_arbiter.sv
// Directed scoreboard bench for l3_ar_qos_arbiter: stimulus queues expected
// outputs, a monitor pops them on every accepted m_ar transfer.
module tb_l3_ar_qos_arbiter;
    logic clk;
    logic rst;

    l3_ar_qos_arbiter_if bus ();

    l3_ar_qos_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [3:0]  src;
        logic [31:0] addr;
        logic [7:0]  len;
        logic        aged;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] addr_tab [16];
    int          errors = 0;
    int          checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int p, input logic aged);
        exp_t e;
        e.src  = 4'(p);
        e.addr = addr_tab[p];
        e.len  = 8'(p);
        e.aged = aged;
        exp_q.push_back(e);
    endtask

    // Monitor: every transfer the pipeline accepts must match the queue head
    initial begin
        exp_t e;
        exp_t act;
        forever begin
            @(negedge clk);
            if (!rst && bus.m_arvalid && bus.m_arready) begin
                act = {bus.m_arsrc, bus.m_araddr, bus.m_arlen, bus.aged_grant};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got src=%0d addr=0x%0h with nothing expected",
                             act.src, act.addr);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL output: got src=%0d addr=0x%0h len=%0d aged=%0b expected src=%0d addr=0x%0h len=%0d aged=%0b",
                                 act.src, act.addr, act.len, act.aged, e.src, e.addr, e.len, e.aged);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.m_arready = 1'b1;
        bus.s_arvalid = 16'h0000;
        for (int p = 0; p < 16; p++) begin
            addr_tab[p]       = 32'hA000_0000 | (32'(p) << 8);
        end
        addr_tab[3] = 32'h0000_1000;
        for (int p = 0; p < 16; p++) begin
            bus.s_araddr[p]  = addr_tab[p];
            bus.s_arlen[p]   = 8'(p);
            bus.s_arsize[p]  = 3'd2;
            bus.s_arburst[p] = 2'd1;
            bus.s_arqos[p]   = 4'd0;
        end

        // Test 1: reset state, then a lone request from port 3
        cycle();
        bus.s_arvalid = 16'h0008;
        bus.s_arqos[3] = 4'd2;
        cycle();
        chk("rst_m_arvalid", 64'(bus.m_arvalid), 64'd0);
        chk("rst_m_arsrc", 64'(bus.m_arsrc), 64'd0);
        chk("rst_aged_grant", 64'(bus.aged_grant), 64'd0);
        chk("rst_s_arready", 64'(bus.s_arready), 64'd0);
        chk("rst_m_araddr", 64'(bus.m_araddr), 64'd0);
        rst = 1'b0;
        #1;
        chk("t1_s_arready", 64'(bus.s_arready), 64'h0008);
        push(3, 1'b0);
        cycle();
        bus.s_arvalid = 16'h0000;
        chk("t1_m_arvalid", 64'(bus.m_arvalid), 64'd1);
        chk("t1_m_araddr", 64'(bus.m_araddr), 64'h1000);
        cycle();

        // Test 2: higher QoS wins first
        bus.s_arqos[1] = 4'd5;
        bus.s_arqos[9] = 4'd12;
        bus.s_arvalid = 16'h0202;
        #1;
        chk("t2_s_arready", 64'(bus.s_arready), 64'h0200);
        push(9, 1'b0);
        cycle();
        bus.s_arvalid = 16'h0002;
        push(1, 1'b0);
        cycle();
        bus.s_arvalid = 16'h0000;
        cycle();
        cycle();

        // Test 3: equal QoS round-robin from a fresh pointer, with 15 -> 0 wrap
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        bus.s_arqos[0]  = 4'd7;
        bus.s_arqos[5]  = 4'd7;
        bus.s_arqos[15] = 4'd7;
        bus.s_arvalid = 16'h8021;
        for (int c = 0; c < 6; c++) begin
            push((c % 3 == 0) ? 0 : ((c % 3 == 1) ? 5 : 15), 1'b0);
            cycle();
        end
        bus.s_arvalid = 16'h0000;
        cycle();
        cycle();

        // Test 4: low-QoS port 2 starves until aged, then its age restarts
        bus.s_arqos[2] = 4'd0;
        bus.s_arqos[4] = 4'd15;
        bus.s_arvalid = 16'h0014;
        for (int c = 0; c < 18; c++) begin
            #1;
            if (c == 15) begin
                chk("t4_aged_s_arready", 64'(bus.s_arready), 64'h0004);
            end else begin
                chk("t4_s_arready", 64'(bus.s_arready), 64'h0010);
            end
            push((c == 15) ? 2 : 4, (c == 15));
            cycle();
        end
        bus.s_arvalid = 16'h0000;
        cycle();
        cycle();

        // Test 5: output hold under back-pressure, then no-bubble refill
        bus.m_arready = 1'b0;
        bus.s_arqos[6] = 4'd3;
        bus.s_arqos[7] = 4'd1;
        bus.s_arvalid = 16'h0040;
        #1;
        chk("t5_first_s_arready", 64'(bus.s_arready), 64'h0040);
        push(6, 1'b0);
        cycle();
        bus.s_arvalid = 16'h0080;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("t5_hold_s_arready", 64'(bus.s_arready), 64'h0000);
            chk("t5_hold_m_arsrc", 64'(bus.m_arsrc), 64'd6);
            chk("t5_hold_m_araddr", 64'(bus.m_araddr), 64'(addr_tab[6]));
            cycle();
        end
        bus.m_arready = 1'b1;
        #1;
        chk("t5_refill_s_arready", 64'(bus.s_arready), 64'h0080);
        push(7, 1'b0);
        cycle();
        bus.s_arvalid = 16'h0000;
        chk("t5_nobubble", 64'({bus.m_arvalid, bus.m_arsrc}), 64'h17);
        cycle();
        cycle();

        // Test 6: asynchronous reset mid-cycle drops a held entry and all ages
        bus.m_arready = 1'b0;
        bus.s_arvalid = 16'h0100;
        cycle();
        bus.s_arvalid = 16'h0400;
        chk("t6_held_m_arvalid", 64'(bus.m_arvalid), 64'd1);
        cycle();
        cycle();
        #2;
        rst = 1'b1;
        #1;
        chk("t6_async_m_arvalid", 64'(bus.m_arvalid), 64'd0);
        chk("t6_async_ages", dut.age_r, 64'd0);
        bus.s_arvalid = 16'h0000;
        cycle();
        rst = 1'b0;
        bus.m_arready = 1'b1;
        for (int p = 0; p < 16; p++) begin
            bus.s_arqos[p] = 4'd9;
        end
        bus.s_arvalid = 16'hFFFF;
        #1;
        chk("t6_tie_s_arready", 64'(bus.s_arready), 64'h0001);
        push(0, 1'b0);
        cycle();
        bus.s_arvalid = 16'h0000;
        cycle();
        cycle();

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/l3_ar_qos_arbiter.md
Name: l3_ar_qos_arbiter

Overview:
- 16-to-1 AXI read-address arbiter that merges the 16 master AR channels into the single request pipeline of the L3 cache slice.
- Sits directly upstream of the L3 cache tag lookup.
- Selects one request per cycle using QoS priority, round-robin tie-break and age-based starvation escape.
- Registers the winner in a one-entry output stage tagged with its source port.

Parameters:
NUM_PORTS, 16, number of master AR channels (port-index width IDX_W = log2(NUM_PORTS) = 4)
ADDR_W, 32, address width
QOS_W, 4, AxQOS width
AGE_MAX, 15, wait cycles after which a pending port becomes "aged" (saturation value of the per-port age counter, 4-bit)

Ports:
clk  input  1  core clock; all logic rising-edge
rst  input  1  asynchronous reset, active-high
s_arvalid  input  [15:0]  per-master request valid
s_arready  output  [15:0]  per-master accept; at most one bit set per cycle
s_araddr  input  [15:0][31:0]  per-master address
s_arlen  input  [15:0][7:0]  per-master burst length
s_arsize  input  [15:0][2:0]  per-master beat size
s_arburst  input  [15:0][1:0]  per-master burst type
s_arqos  input  [15:0][3:0]  per-master QoS; higher value wins
m_arvalid  output  1  request valid to L3 pipeline
m_arready  input  1  L3 pipeline accept
m_araddr  output  32  winner address
m_arlen  output  8  winner burst length
m_arsize  output  3  winner beat size
m_arburst  output  2  winner burst type
m_arqos  output  4  winner QoS
m_arsrc  output  4  index of the winning master port
aged_grant  output  1  one-cycle pulse: current grant was won via the aged rule

Behaviour:
- Reset (rst high, async): clears m_arvalid, all m_ar* payload, m_arsrc, aged_grant, s_arready and all age counters to 0; sets rr_ptr to 15 so port 0 has first round-robin priority. Takes effect immediately, mid-transaction included; any request held in the output stage is dropped.
- Slot free condition: slot_free = !m_arvalid || m_arready.
- Arbitration: runs combinationally every cycle. A grant is issued only when slot_free and at least one s_arvalid is set.
  - s_arready[w]=1 for winner w only; all other bits 0.
  - s_arready may depend on s_arvalid; there is no dependency on m_arready beyond slot_free.
- Winner selection, in strict order:
  1. If any valid port has age == AGE_MAX, choose among aged ports only, by round-robin from rr_ptr+1 (mod 16); QoS is ignored.
  2. Otherwise take the maximum s_arqos among valid ports, then round-robin from rr_ptr+1 among ports at that QoS.
- Grant update: on grant, rr_ptr <= w. The output stage loads the payload and m_arsrc <= w, and sets m_arvalid <= 1 on the next edge (latency 1 cycle from accept to m_arvalid).
- Drain without grant: if m_arvalid && m_arready and there is no new grant, m_arvalid <= 0.
- Throughput: one request per cycle with m_arready held high.
- Output hold: while m_arvalid && !m_arready, all m_ar* and m_arsrc hold stable and all s_arready are 0.
- aged_grant: registered alongside the output stage; 1 for the cycle the aged-rule winner is loaded, else 0.
- Age counters (per port, 4-bit, saturate at AGE_MAX):
  - cleared when the port is granted or s_arvalid is low;
  - otherwise +1 per cycle while s_arvalid is high and the port is not granted, including cycles stalled by a full output slot.
- Simultaneous events:
  - Drain and new grant in the same cycle: the new request replaces the old one with no bubble.
  - All 16 ports aged: pure round-robin.
  - A single valid port wins regardless of QoS.
- Wrap-around: the round-robin search after port 15 continues at port 0.
- Protocol: a master must not drop s_arvalid before acceptance. The arbiter does not check this; a dropped request simply leaves arbitration.

Test Plan:
1. Reset, then port 3 alone with araddr=0x0000_1000, qos=2 → s_arready[3]=1 in cycle 0, m_arvalid=1 in cycle 1 with m_araddr=0x1000, m_arsrc=3, aged_grant=0.
2. Ports 1 (qos=5) and 9 (qos=12) both valid, m_arready=1 → port 9 granted first, port 1 on the next cycle; m_arsrc sequence 9,1.
3. Ports 0, 5 and 15 all qos=7, held valid continuously, m_arready=1 → grant order 0,5,15,0,5,15 (rr_ptr starts at 15); wrap 15→0 verified.
4. Port 2 at qos=0 with port 4 at qos=15 continuously valid → port 2 reaches age 15 and is granted on the 16th cycle with aged_grant=1; its age counter then resets to 0.
5. m_arready held low 5 cycles with m_arvalid=1 → payload stable and s_arready=0 throughout. On the cycle m_arready rises, a pending request is granted, so back-to-back output occurs with no bubble.
6. Assert rst asynchronously mid-cycle while m_arvalid=1 → m_arvalid drops before the next edge, ages cleared. After release, port 0 wins a full-16 tie at equal QoS.
